// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings, the
// controller state type, the default address width and address helpers.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (adds the ERR state).
package lsu_pkg;

  localparam int ADDR_W_DEF = 32;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_WR
`ifdef LSU_MISALIGN_TRAP_EN
    , S_ERR
`endif
  } state_t;

  // Size code 3 behaves exactly like a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] sz);
    return (sz == 2'd3) ? SZ_WORD : sz;
  endfunction

  // True when the low address bits are not a multiple of the access size.
  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] lo);
    return ((sz == SZ_HALF) && lo[0]) || ((sz == SZ_WORD) && (lo != 2'b00));
  endfunction

  // Clears the low address bits that lie below the access size.
  function automatic logic [1:0] align_lo(input logic [1:0] sz, input logic [1:0] lo);
    case (sz)
      SZ_BYTE: return lo;
      SZ_HALF: return {lo[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response handshake between execute stage and LSU, plus the data
// memory pins. slave = LSU side, master = requester, mem = data memory.
interface lsu_if import lsu_pkg::*; #(parameter int ADDR_W = ADDR_W_DEF);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  logic              dm_mem_read;
  logic              dm_mem_write;
  logic [ADDR_W-1:0] dm_addr;
  logic [31:0]       dm_write_data;
  logic [31:0]       dm_read_data;

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output dm_mem_read, dm_mem_write, dm_addr, dm_write_data,
    input  dm_read_data
  );

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport mem (
    input  dm_mem_read, dm_mem_write, dm_addr, dm_write_data,
    output dm_read_data
  );

endinterface

// File: rtl/lsu_lane.sv
// Little-endian lane logic: extracts and extends a byte/half from a memory
// word for loads, and splices store data into the word for sub-word stores.
module lsu_lane import lsu_pkg::*; (
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [15:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] merged
);

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic s);
    logic signed [7:0]  sb;
    logic signed [31:0] sx;
    sb = b;
    sx = sb;
    return s ? sx : {24'd0, b};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic s);
    logic signed [15:0] sh;
    logic signed [31:0] sx;
    sh = h;
    sx = sh;
    return s ? sx : {16'd0, h};
  endfunction

  logic [4:0]  byte_sh;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed lane and build both the load result and merged word.
  always_comb begin
    byte_sh  = {addr_lo, 3'b000};
    byte_sel = word[byte_sh +: 8];
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    load_val = word;
    merged   = word;
    case (size)
      SZ_BYTE: begin
        load_val               = ext8(byte_sel, sgn);
        merged[byte_sh +: 8]   = wdata[7:0];
      end
      SZ_HALF: begin
        load_val = ext16(half_sel, sgn);
        if (addr_lo[1]) merged[31:16] = wdata;
        else            merged[15:0]  = wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one request at a time, sub-word stores done as
// read-modify-write, all memory pins and response outputs registered.
// Optional feature macro: LSU_MISALIGN_TRAP_EN -- misaligned requests return
// resp_err through the ERR state; otherwise low address bits are forced to
// the access alignment and the access proceeds.
module lsu import lsu_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic  clk,
  input  logic  rst_n,
  lsu_if.slave  bus
);

  state_t            state, state_nxt;

  logic              accept;
  logic [1:0]        in_size;
  logic [1:0]        in_lo;
  logic [ADDR_W-1:0] in_waddr;

  logic              lat_write;
  logic              lat_signed;
  logic [1:0]        lat_size;
  logic [1:0]        lat_lo;
  logic [15:0]       lat_wdata;

  logic [31:0]       load_val;
  logic [31:0]       merged;

  logic              rd_q, rd_nxt;
  logic              wr_q, wr_nxt;
  logic              vld_q, vld_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [31:0]       wdata_q, wdata_nxt;
  logic [31:0]       rdata_q, rdata_nxt;
`ifdef LSU_MISALIGN_TRAP_EN
  logic              err_q, err_nxt;
  logic              in_mis;
`endif

  assign accept   = bus.req_valid && (state == S_IDLE);
  assign in_size  = norm_size(bus.req_size);
  assign in_waddr = {bus.req_addr[ADDR_W-1:2], 2'b00};
`ifdef LSU_MISALIGN_TRAP_EN
  assign in_lo    = bus.req_addr[1:0];
  assign in_mis   = misaligned(in_size, bus.req_addr[1:0]);
`else
  assign in_lo    = align_lo(in_size, bus.req_addr[1:0]);
`endif

  lsu_lane u_lane (
    .word     (bus.dm_read_data),
    .addr_lo  (lat_lo),
    .size     (lat_size),
    .sgn      (lat_signed),
    .wdata    (lat_wdata),
    .load_val (load_val),
    .merged   (merged)
  );

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state and next values of the registered memory/response outputs.
  always_comb begin
    state_nxt = state;
    rd_nxt    = 1'b0;
    wr_nxt    = 1'b0;
    vld_nxt   = 1'b0;
    addr_nxt  = addr_q;
    wdata_nxt = wdata_q;
    rdata_nxt = rdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
    err_nxt   = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (accept) begin
`ifdef LSU_MISALIGN_TRAP_EN
          if (in_mis) state_nxt = S_ERR;
          else
`endif
          if (bus.req_write && (in_size == SZ_WORD)) begin
            state_nxt = S_WR;
            wr_nxt    = 1'b1;
            addr_nxt  = in_waddr;
            wdata_nxt = bus.req_wdata;
          end else begin
            state_nxt = S_RD;
            rd_nxt    = 1'b1;
            addr_nxt  = in_waddr;
          end
        end
      end
      S_RD: state_nxt = S_CAP;
      S_CAP: begin
        if (lat_write) begin
          state_nxt = S_WR;
          wr_nxt    = 1'b1;
          wdata_nxt = merged;
        end else begin
          state_nxt = S_IDLE;
          vld_nxt   = 1'b1;
          rdata_nxt = load_val;
        end
      end
      S_WR: begin
        state_nxt = S_IDLE;
        vld_nxt   = 1'b1;
        rdata_nxt = 32'd0;
      end
`ifdef LSU_MISALIGN_TRAP_EN
      S_ERR: begin
        state_nxt = S_IDLE;
        vld_nxt   = 1'b1;
        err_nxt   = 1'b1;
        rdata_nxt = 32'd0;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // Registered memory pins and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      vld_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
`ifdef LSU_MISALIGN_TRAP_EN
      err_q   <= 1'b0;
`endif
    end else begin
      rd_q    <= rd_nxt;
      wr_q    <= wr_nxt;
      vld_q   <= vld_nxt;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
      rdata_q <= rdata_nxt;
`ifdef LSU_MISALIGN_TRAP_EN
      err_q   <= err_nxt;
`endif
    end
  end

  // Capture the request fields needed after the accept cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_write  <= bus.req_write;
      lat_signed <= bus.req_signed;
      lat_size   <= in_size;
      lat_lo     <= in_lo;
      lat_wdata  <= bus.req_wdata[15:0];
    end
  end

  assign bus.req_ready     = (state == S_IDLE);
  assign bus.resp_valid    = vld_q;
  assign bus.resp_rdata    = rdata_q;
  assign bus.dm_mem_read   = rd_q;
  assign bus.dm_mem_write  = wr_q;
  assign bus.dm_addr       = addr_q;
  assign bus.dm_write_data = wdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
  assign bus.resp_err      = err_q;
`else
  assign bus.resp_err      = 1'b0;
`endif

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed requests with hand-computed expected responses
// pushed into a scoreboard queue, checked by a separate response monitor.
`timescale 1ns/1ps
module tb_lsu;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lsu_if #(.ADDR_W(32)) bus();
  lsu #(.ADDR_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Data memory model: registered read, read has priority over write.
  logic [31:0] mem [0:63];
  logic        poke_en;
  logic [5:0]  poke_idx;
  logic [31:0] poke_val;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (poke_en) mem[poke_idx] <= poke_val;
    else if (bus.dm_mem_read) bus.dm_read_data <= mem[bus.dm_addr[7:2]];
    else if (bus.dm_mem_write) mem[bus.dm_addr[7:2]] <= bus.dm_write_data;
    if (bus.dm_mem_read)  rd_cnt <= rd_cnt + 1;
    if (bus.dm_mem_write) wr_cnt <= wr_cnt + 1;
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Response monitor and memory-pin protocol checks.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.resp_valid) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: got resp_valid=1 expected 0 (no request pending)");
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("resp_rdata", bus.resp_rdata, e.rdata);
          chk("resp_err", 32'(bus.resp_err), 32'(e.err));
          chk("resp_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      if (bus.dm_mem_read || bus.dm_mem_write) begin
        chk("dm_rw_overlap", 32'(bus.dm_mem_read && bus.dm_mem_write), 32'd0);
        chk("dm_addr_lo", 32'(bus.dm_addr[1:0]), 32'd0);
      end
    end
  end

  task automatic poke(input int idx, input logic [31:0] val);
    poke_en  = 1'b1;
    poke_idx = 6'(idx);
    poke_val = val;
    @(negedge clk);
    poke_en  = 1'b0;
  endtask

  // Drive one request from a negedge; push its expected response at accept.
  task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input int lat, input bit want_resp);
    int n;
    exp_t e;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: got req_ready=0 expected 1");
      return;
    end
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    if (want_resp) begin
      e.rdata = exp_rd;
      e.err   = exp_err;
      e.cyc   = cyc + 1 + lat;
      sbq.push_back(e);
    end
    @(negedge clk);
    bus.req_valid  = 1'b0;
    bus.req_wdata  = 32'h5A5A_5A5A;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sbq.size());
      sbq.delete();
    end
    @(negedge clk);
  endtask

  // Full transaction: issue, wait for the response, check memory-strobe counts.
  task automatic op(input string name, input logic wr, input logic [1:0] sz,
                    input logic sg, input logic [31:0] addr, input logic [31:0] wd,
                    input logic [31:0] exp_rd, input logic exp_err, input int lat,
                    input int exp_rds, input int exp_wrs);
    int r0, w0;
    r0 = rd_cnt;
    w0 = wr_cnt;
    issue(wr, sz, sg, addr, wd, exp_rd, exp_err, lat, 1'b1);
    drain();
    chk({name, "_reads"}, 32'(rd_cnt - r0), 32'(exp_rds));
    chk({name, "_writes"}, 32'(wr_cnt - w0), 32'(exp_wrs));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int w0;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_size   = SZ_WORD;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    poke_en        = 1'b0;
    poke_idx       = 6'd0;
    poke_val       = 32'd0;
    rst_n          = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst_dm_read", 32'(bus.dm_mem_read), 32'd0);
    chk("rst_dm_write", 32'(bus.dm_mem_write), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_dm_addr", bus.dm_addr, 32'd0);
    chk("rst_dm_wdata", bus.dm_write_data, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Word store then word load at 0x10.
    op("st_w_10", 1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1, 0, 1);
    chk("mem_w4", mem[4], 32'hDEADBEEF);
    op("ld_w_10", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1, 0);
    op("ld_sz3_10", 1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1, 0);

    // Byte loads.
    poke(8, 32'h11223344);
    op("ldb_s_23", 1'b0, SZ_BYTE, 1'b1, 32'h23, 32'h0, 32'h00000011, 1'b0, 2, 1, 0);
    poke(8, 32'h112233F4);
    op("ldb_s_20", 1'b0, SZ_BYTE, 1'b1, 32'h20, 32'h0, 32'hFFFFFFF4, 1'b0, 2, 1, 0);
    op("ldb_u_20", 1'b0, SZ_BYTE, 1'b0, 32'h20, 32'h0, 32'h000000F4, 1'b0, 2, 1, 0);

    // Byte store read-modify-write.
    poke(8, 32'h11223344);
    op("stb_21", 1'b1, SZ_BYTE, 1'b0, 32'h21, 32'hFFFFFFAA, 32'h0, 1'b0, 3, 1, 1);
    chk("mem_stb_21", mem[8], 32'h1122AA44);

    // Halfword load and store.
    poke(8, 32'h80013344);
    op("ldh_s_22", 1'b0, SZ_HALF, 1'b1, 32'h22, 32'h0, 32'hFFFF8001, 1'b0, 2, 1, 0);
    op("ldh_u_22", 1'b0, SZ_HALF, 1'b0, 32'h22, 32'h0, 32'h00008001, 1'b0, 2, 1, 0);
    op("sth_22", 1'b1, SZ_HALF, 1'b0, 32'h22, 32'hFFFF5566, 32'h0, 1'b0, 3, 1, 1);
    chk("mem_sth_22", mem[8], 32'h55663344);
    op("stb_23", 1'b1, SZ_BYTE, 1'b0, 32'h23, 32'h12345677, 32'h0, 1'b0, 3, 1, 1);
    chk("mem_stb_23", mem[8], 32'h77663344);

    // Misaligned accesses.
    poke(1, 32'hCAFEF00D);
    poke(0, 32'hABCD1234);
`ifdef LSU_MISALIGN_TRAP_EN
    op("ld_w_06", 1'b0, SZ_WORD, 1'b0, 32'h06, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    op("ldh_u_03", 1'b0, SZ_HALF, 1'b0, 32'h03, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    op("st_w_05", 1'b1, SZ_WORD, 1'b0, 32'h05, 32'h99999999, 32'h0, 1'b1, 1, 0, 0);
    chk("mem_w1_kept", mem[1], 32'hCAFEF00D);
`else
    op("ld_w_06", 1'b0, SZ_WORD, 1'b0, 32'h06, 32'h0, 32'hCAFEF00D, 1'b0, 2, 1, 0);
    op("ldh_u_03", 1'b0, SZ_HALF, 1'b0, 32'h03, 32'h0, 32'h0000ABCD, 1'b0, 2, 1, 0);
    op("st_w_05", 1'b1, SZ_WORD, 1'b0, 32'h05, 32'h99999999, 32'h0, 1'b0, 1, 0, 1);
    chk("mem_w1_store", mem[1], 32'h99999999);
`endif

    // Reset during CAP of a byte store: no write, no response.
    w0 = wr_cnt;
    issue(1'b1, SZ_BYTE, 1'b0, 32'h20, 32'h00000000, 32'h0, 1'b0, 3, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstmid_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rstmid_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rstmid_dm_write", 32'(bus.dm_mem_write), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rstmid_no_resp", 32'(bus.resp_valid), 32'd0);
    end
    chk("rstmid_ready_after", 32'(bus.req_ready), 32'd1);
    chk("rstmid_writes", 32'(wr_cnt - w0), 32'd0);
    chk("rstmid_mem", mem[8], 32'h77663344);

    // Back-to-back word stores: second accepted in the first's resp_valid cycle.
    issue(1'b1, SZ_WORD, 1'b0, 32'h30, 32'h01020304, 32'h0, 1'b0, 1, 1'b1);
    @(negedge clk);
    chk("b2b_resp_valid", 32'(bus.resp_valid), 32'd1);
    chk("b2b_req_ready", 32'(bus.req_ready), 32'd1);
    issue(1'b1, SZ_WORD, 1'b0, 32'h34, 32'hA5A5A5A5, 32'h0, 1'b0, 1, 1'b1);
    drain();
    chk("mem_b2b_0", mem[12], 32'h01020304);
    chk("mem_b2b_1", mem[13], 32'hA5A5A5A5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
